// File: rtl/stage_skid_reg.sv
// Two-entry pipeline stage (main + skid) with registered ready and NOP-masked control.
// Optional perf counters are enabled with macro STAGE_SKID_PERF_CNT_EN.
module stage_skid_reg #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk_SR,
    input  logic              rst_n_SR,
    input  logic              flush_SR,
    input  logic              valid_in_SR,
    output logic              ready_out_SR,
    input  logic [DATA_W-1:0] data_in_SR,
    input  logic [CTRL_W-1:0] ctrl_in_SR,
    output logic              valid_out_SR,
    input  logic              ready_in_SR,
    output logic [DATA_W-1:0] data_out_SR,
    output logic [CTRL_W-1:0] ctrl_out_SR
`ifdef STAGE_SKID_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt_SR,
    output logic [31:0]       kill_cnt_SR
`endif
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StFull  = 2'd1;
    localparam logic [1:0] StSkid  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic              main_load, main_from_skid, skid_load;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush_SR) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (valid_in_SR) begin
                        main_load = 1'b1;
                        state_d   = StFull;
                    end
                end
                StFull: begin
                    if (valid_in_SR && ready_in_SR) begin
                        main_load = 1'b1;
                    end else if (valid_in_SR) begin
                        skid_load = 1'b1;
                        state_d   = StSkid;
                    end else if (ready_in_SR) begin
                        state_d = StEmpty;
                    end
                end
                StSkid: begin
                    // Upstream is blocked here, so only the drain of skid into main can occur.
                    if (ready_in_SR) begin
                        main_from_skid = 1'b1;
                        state_d        = StFull;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk_SR or negedge rst_n_SR) begin
        if (!rst_n_SR) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q <= state_d;
            if (main_load) begin
                main_data_q <= data_in_SR;
                main_ctrl_q <= ctrl_in_SR;
            end else if (main_from_skid) begin
                main_data_q <= skid_data_q;
                main_ctrl_q <= skid_ctrl_q;
            end
            if (skid_load) begin
                skid_data_q <= data_in_SR;
                skid_ctrl_q <= ctrl_in_SR;
            end
        end
    end

    assign ready_out_SR = (state_q != StSkid);
    assign valid_out_SR = (state_q == StFull) || (state_q == StSkid);
    assign data_out_SR  = main_data_q;
    assign ctrl_out_SR  = valid_out_SR ? main_ctrl_q : '0;

`ifdef STAGE_SKID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, kill_cnt_q;
    logic [1:0]  held_cnt;
    logic [32:0] kill_sum;

    always_comb begin
        held_cnt = 2'd0;
        if (state_q == StFull) held_cnt = 2'd1;
        if (state_q == StSkid) held_cnt = 2'd2;
        kill_sum = {1'b0, kill_cnt_q} + {31'b0, held_cnt};
    end

    always_ff @(posedge clk_SR or negedge rst_n_SR) begin
        if (!rst_n_SR) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            if (valid_out_SR && !ready_in_SR && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_SR) begin
                kill_cnt_q <= kill_sum[32] ? 32'hFFFF_FFFF : kill_sum[31:0];
            end
        end
    end

    assign stall_cnt_SR = stall_cnt_q;
    assign kill_cnt_SR  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_stage_skid_reg.sv
// Bench for stage_skid_reg: directed scenarios plus random traffic against a FIFO-queue model.
module tb_stage_skid_reg;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned CTRL_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              valid_in = 1'b0;
    logic              ready_out;
    logic [DATA_W-1:0] data_in = '0;
    logic [CTRL_W-1:0] ctrl_in = '0;
    logic              valid_out;
    logic              ready_in = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic [CTRL_W-1:0] ctrl_out;
`ifdef STAGE_SKID_PERF_CNT_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       kill_cnt;
    longint unsigned   m_stall = 0;
    longint unsigned   m_kill = 0;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    // Reference: the stage is a 2-deep FIFO; ready when fewer than 2 beats are held.
    logic [DATA_W-1:0] q_data[$];
    logic [CTRL_W-1:0] q_ctrl[$];

    stage_skid_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
    ) dut (
        .clk_SR      (clk),
        .rst_n_SR    (rst_n),
        .flush_SR    (flush),
        .valid_in_SR (valid_in),
        .ready_out_SR(ready_out),
        .data_in_SR  (data_in),
        .ctrl_in_SR  (ctrl_in),
        .valid_out_SR(valid_out),
        .ready_in_SR (ready_in),
        .data_out_SR (data_out),
        .ctrl_out_SR (ctrl_out)
`ifdef STAGE_SKID_PERF_CNT_EN
        ,
        .stall_cnt_SR(stall_cnt),
        .kill_cnt_SR (kill_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        q_data.delete();
        q_ctrl.delete();
`ifdef STAGE_SKID_PERF_CNT_EN
        m_stall = 0;
        m_kill = 0;
`endif
    endtask

    // Drive one cycle's inputs at a negedge, advance the model, wait for the next negedge.
    task automatic cycle(input logic vin, input logic rin, input logic fl,
                         input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        int cnt;
        valid_in = vin;
        ready_in = rin;
        flush    = fl;
        data_in  = d;
        ctrl_in  = c;
        cnt = q_data.size();
`ifdef STAGE_SKID_PERF_CNT_EN
        if (cnt > 0 && !rin && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (fl) m_kill = (m_kill + cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_kill + cnt;
`endif
        if (fl) begin
            q_data.delete();
            q_ctrl.delete();
        end else begin
            if (cnt > 0 && rin) begin
                void'(q_data.pop_front());
                void'(q_ctrl.pop_front());
            end
            if (vin && cnt < 2) begin
                q_data.push_back(d);
                q_ctrl.push_back(c);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1 || data_out !== '0 || ctrl_out !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b r=%b d=%h c=%h, want v=0 r=1 d=0 c=0",
                     valid_out, ready_out, data_out, ctrl_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp;
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, DATA_W'(i), CTRL_W'(16'h10 + i));
            exp = DATA_W'(i);
            n_cmp++;
            if (valid_out !== 1'b1 || data_out !== exp || ready_out !== 1'b1
                || ctrl_out !== CTRL_W'(16'h10 + i)) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got v=%b r=%b d=%h c=%h, want v=1 r=1 d=%h c=%h",
                         i, valid_out, ready_out, data_out, ctrl_out, exp, 16'h10 + i);
            end
        end
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        n_cmp++;
        if (valid_out !== 1'b0 || ctrl_out !== '0) begin
            n_fail++;
            $display("FAIL b2b_drain: got v=%b c=%h, want v=0 c=0", valid_out, ctrl_out);
        end
    endtask

    task automatic test_backpressure();
        cycle(1'b1, 1'b0, 1'b0, DATA_W'(32'hA), CTRL_W'(16'hA));
        cycle(1'b1, 1'b0, 1'b0, DATA_W'(32'hB), CTRL_W'(16'hB));
        n_cmp++;
        if (ready_out !== 1'b0 || valid_out !== 1'b1 || data_out !== DATA_W'(32'hA)) begin
            n_fail++;
            $display("FAIL bp_skid: got r=%b v=%b d=%h, want r=0 v=1 d=a",
                     ready_out, valid_out, data_out);
        end
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        n_cmp++;
        if (valid_out !== 1'b1 || data_out !== DATA_W'(32'hB) || ctrl_out !== CTRL_W'(16'hB)
            || ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: got v=%b r=%b d=%h c=%h, want v=1 r=1 d=b c=b",
                     valid_out, ready_out, data_out, ctrl_out);
        end
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: got v=%b, want v=0", valid_out);
        end
    endtask

    task automatic test_flush();
`ifdef STAGE_SKID_PERF_CNT_EN
        longint unsigned kill_before;
        kill_before = m_kill;
`endif
        cycle(1'b1, 1'b0, 1'b0, DATA_W'(32'h51), CTRL_W'(16'h51));
        cycle(1'b1, 1'b0, 1'b0, DATA_W'(32'h52), CTRL_W'(16'h52));
        cycle(1'b1, 1'b0, 1'b1, DATA_W'(32'hC), CTRL_W'(16'hC));
        n_cmp++;
        if (valid_out !== 1'b0 || ctrl_out !== '0 || ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_skid: got v=%b c=%h r=%b, want v=0 c=0 r=1",
                     valid_out, ctrl_out, ready_out);
        end
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_c: got v=%b d=%h, want v=0", valid_out, data_out);
        end
`ifdef STAGE_SKID_PERF_CNT_EN
        n_cmp++;
        if (64'(kill_cnt) !== kill_before + 2) begin
            n_fail++;
            $display("FAIL flush_kill_cnt: got %0d, want %0d", kill_cnt, kill_before + 2);
        end
`endif
    endtask

    task automatic test_random();
        logic              exp_valid;
        logic [CTRL_W-1:0] exp_ctrl;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 55),
                  1'($urandom_range(0, 99) < 8), rand_data(), CTRL_W'($urandom));
            exp_valid = (q_data.size() > 0);
            exp_ctrl  = exp_valid ? q_ctrl[0] : '0;
            n_cmp++;
            if (valid_out !== exp_valid || ready_out !== (q_data.size() < 2)
                || ctrl_out !== exp_ctrl || (exp_valid && data_out !== q_data[0])) begin
                n_fail++;
                $display("FAIL random_%0d: got v=%b r=%b c=%h d=%h, want v=%b held=%0d c=%h",
                         i, valid_out, ready_out, ctrl_out, data_out, exp_valid,
                         q_data.size(), exp_ctrl);
            end
            // ready_out must not follow ready_in combinationally
            ready_in = ~ready_in;
            #1;
            n_cmp++;
            if (ready_out !== (q_data.size() < 2)) begin
                n_fail++;
                $display("FAIL ready_comb_%0d: got r=%b, want %b", i, ready_out,
                         q_data.size() < 2);
            end
`ifdef STAGE_SKID_PERF_CNT_EN
            n_cmp++;
            if (64'(stall_cnt) !== m_stall || 64'(kill_cnt) !== m_kill) begin
                n_fail++;
                $display("FAIL random_cnt_%0d: got stall=%0d kill=%0d, want %0d %0d",
                         i, stall_cnt, kill_cnt, m_stall, m_kill);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b1, 1'b1, '0, '0);
        cycle(1'b1, 1'b0, 1'b0, DATA_W'(32'hDEAD), CTRL_W'(16'h00FF));
        valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (valid_out !== 1'b0 || ctrl_out !== '0 || data_out !== '0 || ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b c=%h d=%h r=%b, want v=0 c=0 d=0 r=1",
                     valid_out, ctrl_out, data_out, ready_out);
        end
        #1;
        rst_n = 1'b1;
        model_clear();
        cycle(1'b1, 1'b0, 1'b0, DATA_W'(32'h77), CTRL_W'(16'h77));
        n_cmp++;
        if (valid_out !== 1'b1 || data_out !== DATA_W'(32'h77)) begin
            n_fail++;
            $display("FAIL reset_first_accept: got v=%b d=%h, want v=1 d=77", valid_out, data_out);
        end
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
    endtask

`ifdef STAGE_SKID_PERF_CNT_EN
    task automatic test_stall_cnt();
        longint unsigned base;
        cycle(1'b0, 1'b1, 1'b1, '0, '0);
        base = m_stall;
        cycle(1'b1, 1'b0, 1'b0, DATA_W'(32'h5), CTRL_W'(16'h5));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (64'(stall_cnt) !== base + 5) begin
            n_fail++;
            $display("FAIL stall_cnt5: got %0d, want %0d", stall_cnt, base + 5);
        end
        dut.stall_cnt_q = 32'hFFFF_FFFD;
        m_stall = 64'hFFFF_FFFD;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (stall_cnt !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL stall_sat: got %h, want ffffffff", stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset();
`ifdef STAGE_SKID_PERF_CNT_EN
        test_stall_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
